// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common data bus arbiter: source encodings
// and the round-robin grant decision.
package cdb_arbiter_pkg;

    localparam logic CDB_SRC_ALU = 1'b0;
    localparam logic CDB_SRC_MEM = 1'b1;

    // Memory wins when it is the only candidate, or when both compete and
    // the ALU was the previous contested winner.
    function automatic logic cdb_grant_mem(input logic alu_v,
                                           input logic mem_v,
                                           input logic last_grant);
        return mem_v && (!alu_v || (last_grant == CDB_SRC_ALU));
    endfunction

endpackage

// File: rtl/cdb_fifo.sv
// Small per-source result queue. Head is read combinationally; a push and
// a pop in the same cycle are allowed even when the queue is full.
module cdb_fifo #(
    parameter int W     = 36,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  store [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          push_ok;

    assign full    = (count == CW'(DEPTH));
    assign push_ok = push && (!full || pop);
    assign head    = store[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap at DEPTH.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop);
        end
    end

    // Payload storage carries no reset; occupancy decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok && !rst && !clear) store[wr_ptr] <= din;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Merges ALU and load results onto one registered broadcast bus. Each
// source has a short queue with same-cycle bypass; contested cycles are
// resolved round-robin.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int ROB_SIZE_WIDTH = 4,
    parameter int DEPTH          = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      alu_ready,
    input  logic [XLEN-1:0]           alu_res,
    input  logic [ROB_SIZE_WIDTH-1:0] alu_id,
    input  logic                      mem_data_ready,
    input  logic [XLEN-1:0]           mem_data,
    input  logic [ROB_SIZE_WIDTH-1:0] mem_id,
    output logic                      alu_full,
    output logic                      mem_full,
    output logic                      cdb_ready,
    output logic [XLEN-1:0]           cdb_val,
    output logic [ROB_SIZE_WIDTH-1:0] cdb_id,
    output logic                      cdb_src,
    output logic                      cdb_overflow
);

    localparam int EW = XLEN + ROB_SIZE_WIDTH;
    localparam int CW = $clog2(DEPTH) + 1;

    logic [EW-1:0] alu_head, mem_head;
    logic [CW-1:0] alu_cnt, mem_cnt;
    logic          alu_nonempty, mem_nonempty;
    logic          alu_cand_v_p0, mem_cand_v_p0;
    logic [EW-1:0] alu_cand_p0, mem_cand_p0;
    logic          grant_mem_p0, grant_alu_p0, contested_p0;
    logic          alu_pop, mem_pop, alu_push, mem_push;
    logic          alu_drop, mem_drop;
    logic          last_grant;

    cdb_fifo #(.W(EW), .DEPTH(DEPTH)) u_alu_q (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (alu_push && !flush),
        .pop   (alu_pop && !flush),
        .din   ({alu_res, alu_id}),
        .head  (alu_head),
        .count (alu_cnt),
        .full  (alu_full)
    );

    cdb_fifo #(.W(EW), .DEPTH(DEPTH)) u_mem_q (
        .clk   (clk),
        .rst   (rst),
        .clear (flush),
        .push  (mem_push && !flush),
        .pop   (mem_pop && !flush),
        .din   ({mem_data, mem_id}),
        .head  (mem_head),
        .count (mem_cnt),
        .full  (mem_full)
    );

    // Candidate selection (queue head before bypass), grant, and queue control.
    always_comb begin
        alu_nonempty  = (alu_cnt != '0);
        mem_nonempty  = (mem_cnt != '0);
        alu_cand_v_p0 = alu_nonempty || alu_ready;
        mem_cand_v_p0 = mem_nonempty || mem_data_ready;
        alu_cand_p0   = alu_nonempty ? alu_head : {alu_res, alu_id};
        mem_cand_p0   = mem_nonempty ? mem_head : {mem_data, mem_id};
        grant_mem_p0  = cdb_grant_mem(alu_cand_v_p0, mem_cand_v_p0, last_grant);
        grant_alu_p0  = alu_cand_v_p0 && !grant_mem_p0;
        contested_p0  = alu_cand_v_p0 && mem_cand_v_p0;
        alu_pop       = grant_alu_p0 && alu_nonempty;
        mem_pop       = grant_mem_p0 && mem_nonempty;
        // An input is pushed unless it was broadcast directly as a bypass.
        alu_push      = alu_ready && !(grant_alu_p0 && !alu_nonempty);
        mem_push      = mem_data_ready && !(grant_mem_p0 && !mem_nonempty);
        alu_drop      = alu_push && alu_full && !alu_pop;
        mem_drop      = mem_push && mem_full && !mem_pop;
    end

    // ---- stage p1: registered broadcast, round-robin state, overflow flag ----
    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_ready    <= 1'b0;
            cdb_val      <= '0;
            cdb_id       <= '0;
            cdb_src      <= CDB_SRC_ALU;
            cdb_overflow <= 1'b0;
            last_grant   <= CDB_SRC_ALU;
        end else if (flush) begin
            cdb_ready <= 1'b0;
        end else begin
            cdb_ready <= alu_cand_v_p0 || mem_cand_v_p0;
            if (grant_mem_p0) begin
                {cdb_val, cdb_id} <= mem_cand_p0;
                cdb_src           <= CDB_SRC_MEM;
            end else if (grant_alu_p0) begin
                {cdb_val, cdb_id} <= alu_cand_p0;
                cdb_src           <= CDB_SRC_ALU;
            end
            if (contested_p0) last_grant <= grant_mem_p0;
            if (alu_drop || mem_drop) cdb_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter with per-source in-order scoreboards.
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        alu_ready, mem_data_ready;
    logic [31:0] alu_res, mem_data;
    logic [3:0]  alu_id, mem_id;
    logic        alu_full, mem_full, cdb_ready, cdb_src, cdb_overflow;
    logic [31:0] cdb_val;
    logic [3:0]  cdb_id;

    int n_assert = 0;
    int n_fail   = 0;
    logic [35:0] sb_alu[$];
    logic [35:0] sb_mem[$];
    logic        exp_src;

    cdb_arbiter #(.XLEN(32), .ROB_SIZE_WIDTH(4), .DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .alu_ready      (alu_ready),
        .alu_res        (alu_res),
        .alu_id         (alu_id),
        .mem_data_ready (mem_data_ready),
        .mem_data       (mem_data),
        .mem_id         (mem_id),
        .alu_full       (alu_full),
        .mem_full       (mem_full),
        .cdb_ready      (cdb_ready),
        .cdb_val        (cdb_val),
        .cdb_id         (cdb_id),
        .cdb_src        (cdb_src),
        .cdb_overflow   (cdb_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_ready      = 1'b0;
        mem_data_ready = 1'b0;
    endtask

    task automatic drive_alu(input logic [31:0] v, input logic [3:0] id);
        alu_ready = 1'b1;
        alu_res   = v;
        alu_id    = id;
        sb_alu.push_back({v, id});
    endtask

    task automatic drive_mem(input logic [31:0] v, input logic [3:0] id);
        mem_data_ready = 1'b1;
        mem_data       = v;
        mem_id         = id;
        sb_mem.push_back({v, id});
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (sb_alu.size() == 0 && sb_mem.size() == 0 && !cdb_ready) break;
            step();
        end
        chk("drain_alu_left", 64'(sb_alu.size()), 64'd0);
        chk("drain_mem_left", 64'(sb_mem.size()), 64'd0);
    endtask

    // Scoreboard: every broadcast must be the oldest outstanding result of its source.
    always @(negedge clk) begin
        if (!rst && cdb_ready) begin
            if (cdb_src) begin
                chk("sb_mem_pending", 64'(sb_mem.size() != 0), 64'd1);
                if (sb_mem.size() != 0) chk("sb_mem_data", 64'({cdb_val, cdb_id}), 64'(sb_mem.pop_front()));
            end else begin
                chk("sb_alu_pending", 64'(sb_alu.size() != 0), 64'd1);
                if (sb_alu.size() != 0) chk("sb_alu_data", 64'({cdb_val, cdb_id}), 64'(sb_alu.pop_front()));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0;
        alu_res = '0; alu_id = '0; mem_data = '0; mem_id = '0;
        idle();
        repeat (2) step();
        chk("rst_ready", 64'(cdb_ready), 64'd0);
        chk("rst_val", 64'(cdb_val), 64'd0);
        chk("rst_id", 64'(cdb_id), 64'd0);
        chk("rst_src", 64'(cdb_src), 64'd0);
        chk("rst_ovf", 64'(cdb_overflow), 64'd0);
        chk("rst_alu_full", 64'(alu_full), 64'd0);
        chk("rst_mem_full", 64'(mem_full), 64'd0);
        rst = 1'b0;

        // Single uncontested ALU result: one-cycle latency.
        drive_alu(32'h11, 4'd3);
        step(); idle();
        chk("t1_ready", 64'(cdb_ready), 64'd1);
        chk("t1_val", 64'(cdb_val), 64'h11);
        chk("t1_id", 64'(cdb_id), 64'd3);
        chk("t1_src", 64'(cdb_src), 64'd0);
        step();
        chk("t1_ready_off", 64'(cdb_ready), 64'd0);

        // First tie after reset goes to memory, ALU follows with no gap.
        drive_alu(32'hA, 4'd1);
        drive_mem(32'hB, 4'd2);
        step(); idle();
        chk("t2_first_src", 64'(cdb_src), 64'd1);
        chk("t2_first_id", 64'(cdb_id), 64'd2);
        step();
        chk("t2_second_ready", 64'(cdb_ready), 64'd1);
        chk("t2_second_src", 64'(cdb_src), 64'd0);
        chk("t2_second_id", 64'(cdb_id), 64'd1);
        step();
        chk("t2_idle", 64'(cdb_ready), 64'd0);

        // Both producers busy (honouring full flags): grants alternate, ALU first.
        exp_src = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idle();
            if (!alu_full) drive_alu(32'h100 + i, 4'(i));
            if (!mem_full) drive_mem(32'h200 + i, 4'(8 + i));
            step();
            chk("t3_ready", 64'(cdb_ready), 64'd1);
            chk("t3_alternate", 64'(cdb_src), 64'(exp_src));
            exp_src = ~exp_src;
        end
        idle();
        drain();
        chk("t3_no_ovf", 64'(cdb_overflow), 64'd0);

        // ALU three in a row, memory only for two: nothing lost, order kept.
        for (int i = 0; i < 3; i++) begin
            idle();
            drive_alu(32'h300 + i, 4'(i));
            if (i < 2) drive_mem(32'h400 + i, 4'(8 + i));
            step();
        end
        idle();
        drain();

        // Fresh start, then overrun the ALU queue while memory holds the grant.
        rst = 1'b1; step(); rst = 1'b0;
        drive_alu(32'hA0, 4'd0); drive_mem(32'hB0, 4'd8);
        step(); idle();
        chk("t5_c1", 64'({cdb_src, cdb_id}), 64'({1'b1, 4'd8}));
        drive_alu(32'hA1, 4'd1); drive_mem(32'hB1, 4'd9);
        step(); idle();
        chk("t5_c2", 64'({cdb_src, cdb_id}), 64'({1'b0, 4'd0}));
        drive_alu(32'hA2, 4'd2); drive_mem(32'hB2, 4'd10);
        step(); idle();
        chk("t5_c3", 64'({cdb_src, cdb_id}), 64'({1'b1, 4'd9}));
        chk("t5_alu_full", 64'(alu_full), 64'd1);
        drive_alu(32'hA3, 4'd3); drive_mem(32'hB3, 4'd11);
        step(); idle();
        chk("t5_c4", 64'({cdb_src, cdb_id}), 64'({1'b0, 4'd1}));
        alu_ready = 1'b1; alu_res = 32'hA4; alu_id = 4'd4;
        step(); idle();
        chk("t5_c5", 64'({cdb_src, cdb_id}), 64'({1'b1, 4'd10}));
        chk("t5_overflow", 64'(cdb_overflow), 64'd1);
        chk("t5_still_full", 64'(alu_full), 64'd1);
        drive_mem(32'hB4, 4'd12);
        step(); idle();
        chk("t5_c6", 64'({cdb_src, cdb_id}), 64'({1'b0, 4'd2}));
        drive_alu(32'hA5, 4'd5); drive_mem(32'hB5, 4'd13);
        step(); idle();
        chk("t5_c7", 64'({cdb_src, cdb_id}), 64'({1'b1, 4'd11}));
        chk("t6_both_full", 64'({alu_full, mem_full}), 64'b11);

        // Flush with two entries in each queue plus same-cycle inputs.
        flush = 1'b1;
        alu_ready = 1'b1; alu_res = 32'hA6; alu_id = 4'd6;
        mem_data_ready = 1'b1; mem_data = 32'hB6; mem_id = 4'd14;
        step();
        flush = 1'b0; idle();
        sb_alu.delete(); sb_mem.delete();
        chk("t6_flush_ready", 64'(cdb_ready), 64'd0);
        chk("t6_flush_full", 64'({alu_full, mem_full}), 64'b00);
        chk("t6_ovf_held", 64'(cdb_overflow), 64'd1);
        step();
        chk("t6_flush_quiet", 64'(cdb_ready), 64'd0);
        drive_mem(32'hB7, 4'd15);
        step(); idle();
        chk("t6_post_ready", 64'(cdb_ready), 64'd1);
        chk("t6_post_bus", 64'({cdb_src, cdb_val, cdb_id}), 64'({1'b1, 32'hB7, 4'd15}));
        step();
        chk("t6_post_idle", 64'(cdb_ready), 64'd0);
        chk("t6_sb_empty", 64'(sb_alu.size() + sb_mem.size()), 64'd0);

        // Reset outranks flush and clears the sticky flag.
        rst = 1'b1; flush = 1'b1;
        alu_ready = 1'b1; alu_res = 32'hC0; alu_id = 4'd7;
        mem_data_ready = 1'b1; mem_data = 32'hD0; mem_id = 4'd5;
        step();
        idle(); flush = 1'b0;
        chk("t7_bus", 64'({cdb_ready, cdb_src, cdb_val, cdb_id}), 64'd0);
        chk("t7_ovf", 64'(cdb_overflow), 64'd0);
        chk("t7_full", 64'({alu_full, mem_full}), 64'b00);
        rst = 1'b0;
        step();
        chk("t7_idle", 64'(cdb_ready), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
